exc_commit_ctrl: RTL and testbench
==================================

Name: exc_commit_ctrl

Overview:
- Sequences exception, interrupt and ERTN commits from the WB stage into the CSR block.
- Arbitrates the three event sources and generates the one-cycle CSR update pulses (`wb_ex` / `ertn_flush`).
- Holds the whole pipeline flushed until the fetch stage accepts the redirect PC (EENTRY or ERA).
- Sits between WB, the CSR file and IF in mycpu_top.

Parameters:
- ECODE_INT, 6'h0: ecode reported for an interrupt.
- CNT_W, 16: width of the saturating taken-event counter.

Ports:
- clk  in  1  core clock
- resetn  in  1  asynchronous, active-low reset
- ws_valid  in  1  WB holds a valid instruction
- ws_ex  in  1  WB instruction raised an exception
- ws_ecode  in  6  exception code
- ws_esubcode  in  9  exception subcode
- ws_pc  in  32  WB instruction PC
- ws_vaddr  in  32  faulting data address
- ws_ertn  in  1  WB instruction is ERTN
- has_int  in  1  interrupt pending, from the CSR block
- csr_eentry  in  32  exception entry vector
- csr_era  in  32  current ERA value
- ws_commit  out  1  WB instruction may retire (regfile write enable qualifier)
- ws_allowin  out  1  WB may accept a new instruction
- csr_wb_ex  out  1  one-cycle exception-commit pulse to the CSR block
- csr_ertn_flush  out  1  one-cycle ERTN pulse to the CSR block
- csr_ecode  out  6  latched ecode
- csr_esubcode  out  9  latched esubcode
- csr_pc  out  32  latched PC
- csr_vaddr  out  32  latched vaddr
- flush_all  out  1  kill every pipeline stage
- redirect_valid  out  1  redirect request to IF
- redirect_pc  out  32  redirect target
- redirect_ready  in  1  IF accepts the redirect
- ev_cnt  out  CNT_W  saturating count of taken exceptions and interrupts (ERTN is not counted)

Behaviour:
- States: IDLE, COMMIT, REDIRECT. Encoding is 2 bits; the unused encoding returns to IDLE.
- Event definition: `event = ws_valid & (has_int | ws_ex | ws_ertn)`, evaluated only in IDLE.
- Priority: `has_int` > `ws_ex` > `ws_ertn`.
  - Interrupt: latches ecode = ECODE_INT, esubcode = 0, pc = ws_pc, vaddr = ws_vaddr.
  - Exception: latches the ws_* fields.
  - ERTN: latches kind only; ecode, esubcode, pc and vaddr registers keep their old values.
  - A latched `kind_ertn` flag records the event type.
- `has_int` while `ws_valid` = 0 is not taken. The interrupt stays pending in the CSR block and is taken at the next valid WB instruction.
- IDLE:
  - `ws_commit = ws_valid & ~event` (combinational). The excepting or interrupted instruction never retires; ERTN does not retire either.
  - `flush_all = event` (combinational, same cycle).
  - `ws_allowin = ~event`.
  - On event, go to COMMIT.
- COMMIT (exactly 1 cycle):
  - `csr_wb_ex = ~kind_ertn`; `csr_ertn_flush = kind_ertn`.
  - csr_* fields are driven from the latches.
  - Capture `redirect_pc = kind_ertn ? csr_era : csr_eentry`. The CSR block updates ERA on this same edge, so the pre-update ERA is used for ERTN. EENTRY is unaffected by commits.
  - `ev_cnt` += 1 if not ERTN, saturating at all-ones.
  - Go to REDIRECT.
- REDIRECT:
  - `redirect_valid = 1`; `redirect_pc` is held stable.
  - When `redirect_valid & redirect_ready`, go to IDLE on the next edge.
  - `ready` may be high on the first REDIRECT cycle, giving a minimum event-to-IDLE latency of 3 cycles.
  - There is no timeout; the block waits indefinitely.
- `flush_all` = 1 and `ws_allowin` = 0 throughout COMMIT and REDIRECT, including the handshake cycle. `ws_commit` = 0 outside IDLE.
- `csr_wb_ex` and `csr_ertn_flush` are never high together and never high outside COMMIT.
- Input changes during COMMIT or REDIRECT are ignored; nothing is queued.
- Reset (asynchronous, any state): state = IDLE and all registered outputs clear:
  - `csr_wb_ex`, `csr_ertn_flush`, `redirect_valid`, `redirect_pc`, `csr_ecode`, `csr_esubcode`, `csr_pc`, `csr_vaddr`, `ev_cnt` = 0.
  - Combinational outputs follow IDLE with inputs masked by `ws_valid`.
- `redirect_pc` is registered. All pulses are registered, so no combinational path runs from `redirect_ready` to the csr_* outputs.

Decomposition:
- Shared package `cpu_defs`:
  - State encodings ST_IDLE = 2'd0, ST_COMMIT = 2'd1, ST_REDIRECT = 2'd2.
  - ecode constants: ECODE_INT = 6'h0, ECODE_ADE = 6'h8, ECODE_ALE = 6'h9, ECODE_BRK = 6'hc, ECODE_INE = 6'hd.
- No sub-module; the saturating counter is inline.

Test Plan:
- ws_valid=1, ws_ex=1, ecode=6'hc, pc=32'h1c000100, csr_eentry=32'h1c008000, ready=1 →
  - cycle0: flush_all=1, ws_commit=0.
  - cycle1: csr_wb_ex=1, csr_ecode=6'hc, csr_pc=32'h1c000100.
  - cycle2: redirect_valid=1, redirect_pc=32'h1c008000.
  - cycle3: IDLE; ev_cnt=1.
- ws_ertn=1, csr_era=32'h1c000200 → cycle1: csr_ertn_flush=1, csr_wb_ex=0; cycle2: redirect_pc=32'h1c000200; ev_cnt unchanged.
- has_int=1 with ws_ex=1 (ecode 6'h9) on the same valid instruction → csr_ecode=6'h0, esubcode=0; has_int=1 with ws_valid=0 → no flush.
- Hold redirect_ready=0 for 5 cycles → redirect_valid and redirect_pc stable, flush_all=1, ws_allowin=0 throughout; IDLE one cycle after ready rises.
- Deassert resetn during REDIRECT → redirect_valid, flush_all and ev_cnt = 0 immediately, without waiting for a clock edge; the next event after release is sequenced normally.
- CNT_W=2, 5 back-to-back exceptions → ev_cnt reads 1, 2, 3, 3, 3.

Source files
------------

// File: rtl/exc_commit_ctrl_pkg.sv
// Shared CPU definitions: commit-controller state encodings, exception codes
// and the record latched when an exception or interrupt is taken.
package cpu_defs;

    localparam logic [1:0] ST_IDLE     = 2'd0;
    localparam logic [1:0] ST_COMMIT   = 2'd1;
    localparam logic [1:0] ST_REDIRECT = 2'd2;

    localparam logic [5:0] ECODE_INT = 6'h0;
    localparam logic [5:0] ECODE_ADE = 6'h8;
    localparam logic [5:0] ECODE_ALE = 6'h9;
    localparam logic [5:0] ECODE_BRK = 6'hc;
    localparam logic [5:0] ECODE_INE = 6'hd;

    typedef struct packed {
        logic [5:0]  ecode;
        logic [8:0]  esubcode;
        logic [31:0] pc;
        logic [31:0] vaddr;
    } exc_info_t;

endpackage

// File: rtl/exc_commit_ctrl_if.sv
// WB / CSR / IF-redirect signal bundle around the exception commit controller.
// The master side is the controller; the slave side is the rest of the core.
interface exc_commit_ctrl_if #(
    parameter int CNT_W = 16
);
    logic              ws_valid;
    logic              ws_ex;
    logic [5:0]        ws_ecode;
    logic [8:0]        ws_esubcode;
    logic [31:0]       ws_pc;
    logic [31:0]       ws_vaddr;
    logic              ws_ertn;
    logic              has_int;
    logic [31:0]       csr_eentry;
    logic [31:0]       csr_era;
    logic              ws_commit;
    logic              ws_allowin;
    logic              csr_wb_ex;
    logic              csr_ertn_flush;
    logic [5:0]        csr_ecode;
    logic [8:0]        csr_esubcode;
    logic [31:0]       csr_pc;
    logic [31:0]       csr_vaddr;
    logic              flush_all;
    logic              redirect_valid;
    logic [31:0]       redirect_pc;
    logic              redirect_ready;
    logic [CNT_W-1:0]  ev_cnt;

    modport master (
        input  ws_valid, ws_ex, ws_ecode, ws_esubcode, ws_pc, ws_vaddr, ws_ertn,
        input  has_int, csr_eentry, csr_era, redirect_ready,
        output ws_commit, ws_allowin, csr_wb_ex, csr_ertn_flush,
        output csr_ecode, csr_esubcode, csr_pc, csr_vaddr,
        output flush_all, redirect_valid, redirect_pc, ev_cnt
    );

    modport slave (
        output ws_valid, ws_ex, ws_ecode, ws_esubcode, ws_pc, ws_vaddr, ws_ertn,
        output has_int, csr_eentry, csr_era, redirect_ready,
        input  ws_commit, ws_allowin, csr_wb_ex, csr_ertn_flush,
        input  csr_ecode, csr_esubcode, csr_pc, csr_vaddr,
        input  flush_all, redirect_valid, redirect_pc, ev_cnt
    );

endinterface

// File: rtl/exc_commit_ctrl.sv
// Sequences interrupt / exception / ERTN commits from WB into the CSR file and
// keeps the pipeline flushed until IF accepts the EENTRY or ERA redirect.
module exc_commit_ctrl #(
    parameter logic [5:0] ECODE_INT = 6'h0,
    parameter int         CNT_W     = 16
) (
    input  logic                      clk,
    input  logic                      resetn,
    exc_commit_ctrl_if.master         bus
);
    import cpu_defs::*;

    logic [1:0]       state_q;
    logic [1:0]       state_d;
    logic             kind_ertn_q;
    exc_info_t        info_q;
    logic             wb_ex_q;
    logic             ertn_flush_q;
    logic             redirect_valid_q;
    logic [31:0]      redirect_pc_q;
    logic [CNT_W-1:0] ev_cnt_q;

    logic in_idle;
    logic take_event;
    logic take_ertn;

    assign in_idle    = (state_q == ST_IDLE);
    assign take_event = in_idle & bus.ws_valid & (bus.has_int | bus.ws_ex | bus.ws_ertn);
    // ERTN loses to both interrupt and exception on the same instruction.
    assign take_ertn  = ~bus.has_int & ~bus.ws_ex & bus.ws_ertn;

    // NOTE: state_d gets a default before the case so no path leaves it unassigned (no latch).
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:     if (take_event) state_d = ST_COMMIT;
            ST_COMMIT:   state_d = ST_REDIRECT;
            ST_REDIRECT: if (redirect_valid_q & bus.redirect_ready) state_d = ST_IDLE;
            default:     state_d = ST_IDLE;
        endcase
    end

    // NOTE: all sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ERTN records only its kind; the CSR fields keep whatever the last exception left.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            kind_ertn_q <= 1'b0;
            info_q      <= '0;
        end else if (take_event) begin
            kind_ertn_q <= take_ertn;
            if (bus.has_int) begin
                info_q <= '{ecode: ECODE_INT, esubcode: 9'd0,
                            pc: bus.ws_pc, vaddr: bus.ws_vaddr};
            end else if (bus.ws_ex) begin
                info_q <= '{ecode: bus.ws_ecode, esubcode: bus.ws_esubcode,
                            pc: bus.ws_pc, vaddr: bus.ws_vaddr};
            end
        end
    end

    // Pulses are set on the IDLE->COMMIT edge, so they are high for exactly the COMMIT cycle.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wb_ex_q      <= 1'b0;
            ertn_flush_q <= 1'b0;
        end else begin
            wb_ex_q      <= take_event & ~take_ertn;
            ertn_flush_q <= take_event & take_ertn;
        end
    end

    // ERA is sampled in COMMIT, before the CSR block overwrites it on the same edge.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            redirect_valid_q <= 1'b0;
            redirect_pc_q    <= 32'd0;
        end else begin
            redirect_valid_q <= (state_q == ST_COMMIT) |
                                ((state_q == ST_REDIRECT) & ~bus.redirect_ready);
            if (state_q == ST_COMMIT) begin
                redirect_pc_q <= kind_ertn_q ? bus.csr_era : bus.csr_eentry;
            end
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            ev_cnt_q <= '0;
        end else if ((state_q == ST_COMMIT) && !kind_ertn_q && !(&ev_cnt_q)) begin
            ev_cnt_q <= ev_cnt_q + CNT_W'(1);
        end
    end

    assign bus.ws_commit      = in_idle & bus.ws_valid & ~take_event;
    assign bus.ws_allowin     = in_idle & ~take_event;
    assign bus.flush_all      = ~in_idle | take_event;
    assign bus.csr_wb_ex      = wb_ex_q;
    assign bus.csr_ertn_flush = ertn_flush_q;
    assign bus.csr_ecode      = info_q.ecode;
    assign bus.csr_esubcode   = info_q.esubcode;
    assign bus.csr_pc         = info_q.pc;
    assign bus.csr_vaddr      = info_q.vaddr;
    assign bus.redirect_valid = redirect_valid_q;
    assign bus.redirect_pc    = redirect_pc_q;
    assign bus.ev_cnt         = ev_cnt_q;

endmodule

// File: tb/tb_exc_commit_ctrl.sv
// Bench for exc_commit_ctrl: directed scenarios plus a random run against a
// transaction-level model; a second instance with a 2-bit counter checks saturation.
module tb_exc_commit_ctrl;
    import cpu_defs::*;

    logic clk = 1'b0;
    logic resetn;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    exc_commit_ctrl_if #(.CNT_W(16)) bus ();
    exc_commit_ctrl_if #(.CNT_W(2))  bus2 ();

    assign bus2.ws_valid       = bus.ws_valid;
    assign bus2.ws_ex          = bus.ws_ex;
    assign bus2.ws_ecode       = bus.ws_ecode;
    assign bus2.ws_esubcode    = bus.ws_esubcode;
    assign bus2.ws_pc          = bus.ws_pc;
    assign bus2.ws_vaddr       = bus.ws_vaddr;
    assign bus2.ws_ertn        = bus.ws_ertn;
    assign bus2.has_int        = bus.has_int;
    assign bus2.csr_eentry     = bus.csr_eentry;
    assign bus2.csr_era        = bus.csr_era;
    assign bus2.redirect_ready = bus.redirect_ready;

    exc_commit_ctrl #(.ECODE_INT(ECODE_INT), .CNT_W(16)) dut (
        .clk(clk), .resetn(resetn), .bus(bus)
    );
    exc_commit_ctrl #(.ECODE_INT(ECODE_INT), .CNT_W(2)) dut_sat (
        .clk(clk), .resetn(resetn), .bus(bus2)
    );

    task automatic clear_inputs();
        bus.ws_valid       = 1'b0;
        bus.ws_ex          = 1'b0;
        bus.ws_ecode       = 6'h0;
        bus.ws_esubcode    = 9'h0;
        bus.ws_pc          = 32'h0;
        bus.ws_vaddr       = 32'h0;
        bus.ws_ertn        = 1'b0;
        bus.has_int        = 1'b0;
        bus.csr_eentry     = 32'h1c008000;
        bus.csr_era        = 32'h0;
        bus.redirect_ready = 1'b1;
    endtask

    task automatic apply_reset();
        @(negedge clk);
        resetn = 1'b0;
        clear_inputs();
        @(negedge clk);
        resetn = 1'b1;
    endtask

    task automatic test_reset();
        resetn = 1'b0;
        clear_inputs();
        #12;
        total++; if (bus.csr_wb_ex !== 1'b0) begin bad++; $display("FAIL rst_wb_ex: got=%0h want=0", bus.csr_wb_ex); end
        total++; if (bus.csr_ertn_flush !== 1'b0) begin bad++; $display("FAIL rst_ertn: got=%0h want=0", bus.csr_ertn_flush); end
        total++; if (bus.redirect_valid !== 1'b0) begin bad++; $display("FAIL rst_rvalid: got=%0h want=0", bus.redirect_valid); end
        total++; if (bus.redirect_pc !== 32'h0) begin bad++; $display("FAIL rst_rpc: got=%h want=0", bus.redirect_pc); end
        total++; if ({bus.csr_ecode, bus.csr_esubcode, bus.csr_pc, bus.csr_vaddr} !== 79'h0) begin
            bad++; $display("FAIL rst_csr_fields: got=%h want=0", {bus.csr_ecode, bus.csr_esubcode, bus.csr_pc, bus.csr_vaddr}); end
        total++; if (bus.ev_cnt !== 16'h0) begin bad++; $display("FAIL rst_ev_cnt: got=%0d want=0", bus.ev_cnt); end
        total++; if (bus.flush_all !== 1'b0 || bus.ws_allowin !== 1'b1) begin
            bad++; $display("FAIL rst_flush_allowin: got=%0b%0b want=01", bus.flush_all, bus.ws_allowin); end
        @(negedge clk);
        resetn = 1'b1;
        @(negedge clk);
        bus.ws_valid = 1'b1;
        #1;
        total++; if (bus.ws_commit !== 1'b1 || bus.flush_all !== 1'b0) begin
            bad++; $display("FAIL plain_commit: got commit=%0b flush=%0b want 1/0", bus.ws_commit, bus.flush_all); end
        bus.ws_valid = 1'b0;
    endtask

    task automatic test_exception();
        @(negedge clk);
        clear_inputs();
        bus.ws_valid = 1'b1; bus.ws_ex = 1'b1; bus.ws_ecode = ECODE_BRK; bus.ws_pc = 32'h1c000100;
        #1;
        total++; if (bus.flush_all !== 1'b1 || bus.ws_commit !== 1'b0 || bus.ws_allowin !== 1'b0) begin
            bad++; $display("FAIL exc_c0: got flush=%0b commit=%0b allowin=%0b want 1/0/0", bus.flush_all, bus.ws_commit, bus.ws_allowin); end
        @(negedge clk);
        bus.ws_valid = 1'b0; bus.ws_ex = 1'b0;
        #1;
        total++; if (bus.csr_wb_ex !== 1'b1 || bus.csr_ertn_flush !== 1'b0) begin
            bad++; $display("FAIL exc_c1_pulse: got wb_ex=%0b ertn=%0b want 1/0", bus.csr_wb_ex, bus.csr_ertn_flush); end
        total++; if (bus.csr_ecode !== 6'hc || bus.csr_pc !== 32'h1c000100) begin
            bad++; $display("FAIL exc_c1_fields: got ecode=%h pc=%h want c/1c000100", bus.csr_ecode, bus.csr_pc); end
        @(negedge clk); #1;
        total++; if (bus.redirect_valid !== 1'b1 || bus.redirect_pc !== 32'h1c008000 || bus.csr_wb_ex !== 1'b0) begin
            bad++; $display("FAIL exc_c2: got rv=%0b rpc=%h wb_ex=%0b want 1/1c008000/0", bus.redirect_valid, bus.redirect_pc, bus.csr_wb_ex); end
        @(negedge clk); #1;
        total++; if (bus.flush_all !== 1'b0 || bus.redirect_valid !== 1'b0 || bus.ws_allowin !== 1'b1 || bus.ev_cnt !== 16'd1) begin
            bad++; $display("FAIL exc_c3: got flush=%0b rv=%0b allowin=%0b cnt=%0d want 0/0/1/1", bus.flush_all, bus.redirect_valid, bus.ws_allowin, bus.ev_cnt); end
    endtask

    task automatic test_ertn();
        @(negedge clk);
        bus.ws_valid = 1'b1; bus.ws_ertn = 1'b1; bus.csr_era = 32'h1c000200;
        #1;
        total++; if (bus.flush_all !== 1'b1 || bus.ws_commit !== 1'b0) begin
            bad++; $display("FAIL ertn_c0: got flush=%0b commit=%0b want 1/0", bus.flush_all, bus.ws_commit); end
        @(negedge clk);
        bus.ws_valid = 1'b0; bus.ws_ertn = 1'b0;
        #1;
        total++; if (bus.csr_ertn_flush !== 1'b1 || bus.csr_wb_ex !== 1'b0) begin
            bad++; $display("FAIL ertn_c1_pulse: got ertn=%0b wb_ex=%0b want 1/0", bus.csr_ertn_flush, bus.csr_wb_ex); end
        total++; if (bus.csr_ecode !== 6'hc || bus.csr_pc !== 32'h1c000100) begin
            bad++; $display("FAIL ertn_keeps_fields: got ecode=%h pc=%h want c/1c000100", bus.csr_ecode, bus.csr_pc); end
        @(negedge clk);
        bus.csr_era = 32'hdead0000;
        #1;
        total++; if (bus.redirect_valid !== 1'b1 || bus.redirect_pc !== 32'h1c000200 || bus.ev_cnt !== 16'd1) begin
            bad++; $display("FAIL ertn_c2: got rv=%0b rpc=%h cnt=%0d want 1/1c000200/1", bus.redirect_valid, bus.redirect_pc, bus.ev_cnt); end
        @(negedge clk);
        bus.csr_era = 32'h0;
        #1;
        total++; if (bus.flush_all !== 1'b0) begin bad++; $display("FAIL ertn_c3_idle: got flush=%0b want 0", bus.flush_all); end
    endtask

    task automatic test_int_priority();
        @(negedge clk);
        bus.ws_valid = 1'b1; bus.has_int = 1'b1; bus.ws_ex = 1'b1; bus.ws_ertn = 1'b1;
        bus.ws_ecode = ECODE_ALE; bus.ws_esubcode = 9'h1a; bus.ws_pc = 32'h1c000300; bus.ws_vaddr = 32'h00001234;
        #1;
        total++; if (bus.flush_all !== 1'b1) begin bad++; $display("FAIL int_c0_flush: got=%0b want 1", bus.flush_all); end
        @(negedge clk);
        clear_inputs();
        #1;
        total++; if (bus.csr_wb_ex !== 1'b1 || bus.csr_ertn_flush !== 1'b0) begin
            bad++; $display("FAIL int_c1_pulse: got wb_ex=%0b ertn=%0b want 1/0", bus.csr_wb_ex, bus.csr_ertn_flush); end
        total++; if (bus.csr_ecode !== ECODE_INT || bus.csr_esubcode !== 9'h0 || bus.csr_pc !== 32'h1c000300 || bus.csr_vaddr !== 32'h1234) begin
            bad++; $display("FAIL int_c1_fields: got ecode=%h esub=%h pc=%h vaddr=%h want 0/0/1c000300/1234",
                            bus.csr_ecode, bus.csr_esubcode, bus.csr_pc, bus.csr_vaddr); end
        @(negedge clk); #1;
        total++; if (bus.redirect_pc !== 32'h1c008000 || bus.ev_cnt !== 16'd2) begin
            bad++; $display("FAIL int_c2: got rpc=%h cnt=%0d want 1c008000/2", bus.redirect_pc, bus.ev_cnt); end
        @(negedge clk);
        bus.has_int = 1'b1;
        #1;
        total++; if (bus.flush_all !== 1'b0 || bus.ws_allowin !== 1'b1 || bus.ws_commit !== 1'b0) begin
            bad++; $display("FAIL int_novalid_c0: got flush=%0b allowin=%0b commit=%0b want 0/1/0", bus.flush_all, bus.ws_allowin, bus.ws_commit); end
        @(negedge clk); #1;
        total++; if (bus.csr_wb_ex !== 1'b0 || bus.flush_all !== 1'b0) begin
            bad++; $display("FAIL int_novalid_c1: got wb_ex=%0b flush=%0b want 0/0", bus.csr_wb_ex, bus.flush_all); end
        bus.has_int = 1'b0;
    endtask

    task automatic test_ready_stall();
        @(negedge clk);
        bus.ws_valid = 1'b1; bus.ws_ex = 1'b1; bus.ws_ecode = ECODE_INE; bus.ws_pc = 32'h1c000400;
        bus.redirect_ready = 1'b0;
        @(negedge clk);
        bus.ws_valid = 1'b0; bus.ws_ex = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            bus.ws_valid = 1'b1; bus.ws_ex = 1'b1; bus.ws_ecode = ECODE_ADE;
            #1;
            total++; if (bus.redirect_valid !== 1'b1 || bus.redirect_pc !== 32'h1c008000 || bus.flush_all !== 1'b1 ||
                         bus.ws_allowin !== 1'b0 || bus.ws_commit !== 1'b0 || bus.csr_ecode !== ECODE_INE) begin
                bad++; $display("FAIL stall_k%0d: got rv=%0b rpc=%h flush=%0b allowin=%0b commit=%0b ecode=%h want 1/1c008000/1/0/0/d",
                                k, bus.redirect_valid, bus.redirect_pc, bus.flush_all, bus.ws_allowin, bus.ws_commit, bus.csr_ecode); end
        end
        @(negedge clk);
        clear_inputs();
        #1;
        total++; if (bus.redirect_valid !== 1'b1 || bus.flush_all !== 1'b1 || bus.ws_allowin !== 1'b0) begin
            bad++; $display("FAIL stall_handshake: got rv=%0b flush=%0b allowin=%0b want 1/1/0", bus.redirect_valid, bus.flush_all, bus.ws_allowin); end
        @(negedge clk); #1;
        total++; if (bus.redirect_valid !== 1'b0 || bus.flush_all !== 1'b0 || bus.ev_cnt !== 16'd3) begin
            bad++; $display("FAIL stall_release: got rv=%0b flush=%0b cnt=%0d want 0/0/3", bus.redirect_valid, bus.flush_all, bus.ev_cnt); end
    endtask

    task automatic test_async_reset();
        @(negedge clk);
        bus.ws_valid = 1'b1; bus.ws_ex = 1'b1; bus.ws_ecode = ECODE_BRK; bus.redirect_ready = 1'b0;
        @(negedge clk);
        bus.ws_valid = 1'b0; bus.ws_ex = 1'b0;
        @(negedge clk); #1;
        total++; if (bus.redirect_valid !== 1'b1 || bus.ev_cnt !== 16'd4) begin
            bad++; $display("FAIL arst_pre: got rv=%0b cnt=%0d want 1/4", bus.redirect_valid, bus.ev_cnt); end
        #1;
        resetn = 1'b0;
        #1;
        total++; if (bus.redirect_valid !== 1'b0 || bus.flush_all !== 1'b0 || bus.ev_cnt !== 16'd0 ||
                     bus.redirect_pc !== 32'h0 || bus2.ev_cnt !== 2'd0) begin
            bad++; $display("FAIL arst_now: got rv=%0b flush=%0b cnt=%0d rpc=%h cnt2=%0d want 0/0/0/0/0",
                            bus.redirect_valid, bus.flush_all, bus.ev_cnt, bus.redirect_pc, bus2.ev_cnt); end
        @(negedge clk);
        resetn = 1'b1;
        bus.redirect_ready = 1'b1;
        @(negedge clk);
        bus.ws_valid = 1'b1; bus.ws_ex = 1'b1; bus.ws_ecode = ECODE_ADE; bus.ws_pc = 32'h1c000500;
        #1;
        total++; if (bus.flush_all !== 1'b1) begin bad++; $display("FAIL arst_after_c0: got flush=%0b want 1", bus.flush_all); end
        @(negedge clk);
        clear_inputs();
        #1;
        total++; if (bus.csr_wb_ex !== 1'b1 || bus.csr_ecode !== ECODE_ADE || bus.csr_pc !== 32'h1c000500) begin
            bad++; $display("FAIL arst_after_c1: got wb_ex=%0b ecode=%h pc=%h want 1/8/1c000500", bus.csr_wb_ex, bus.csr_ecode, bus.csr_pc); end
        @(negedge clk); #1;
        total++; if (bus.redirect_valid !== 1'b1 || bus.ev_cnt !== 16'd1) begin
            bad++; $display("FAIL arst_after_c2: got rv=%0b cnt=%0d want 1/1", bus.redirect_valid, bus.ev_cnt); end
        @(negedge clk); #1;
        total++; if (bus.flush_all !== 1'b0) begin bad++; $display("FAIL arst_after_c3: got flush=%0b want 0", bus.flush_all); end
    endtask

    task automatic test_saturation();
        int n;
        apply_reset();
        @(negedge clk);
        bus.ws_valid = 1'b1; bus.ws_ex = 1'b1; bus.ws_ecode = ECODE_BRK; bus.ws_pc = 32'h1c000600;
        for (int k = 0; k < 15; k++) begin
            #1;
            n = k / 3 + 1;
            if (k % 3 == 1) begin
                total++; if (bus.csr_wb_ex !== 1'b1) begin bad++; $display("FAIL b2b_pulse_%0d: got=%0b want 1", n, bus.csr_wb_ex); end
            end
            if (k % 3 == 2) begin
                total++; if (bus2.ev_cnt !== 2'((n > 3) ? 3 : n) || bus.ev_cnt !== 16'(n)) begin
                    bad++; $display("FAIL b2b_cnt_%0d: got cnt2=%0d cnt=%0d want %0d/%0d", n, bus2.ev_cnt, bus.ev_cnt, (n > 3) ? 3 : n, n); end
            end
            @(negedge clk);
        end
        clear_inputs();
    endtask

    task automatic test_random(input int cycles);
        int          age;
        int          cnt;
        int          cnt2;
        bit          kind_ertn;
        bit          idle;
        bit          ev;
        logic [5:0]  m_ecode;
        logic [8:0]  m_esub;
        logic [31:0] m_pc;
        logic [31:0] m_vaddr;
        logic [31:0] m_rpc;
        logic [31:0] eentry;
        apply_reset();
        age = -1; cnt = 0; cnt2 = 0; kind_ertn = 1'b0;
        m_ecode = '0; m_esub = '0; m_pc = '0; m_vaddr = '0; m_rpc = '0;
        eentry = $urandom;
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            bus.ws_valid       = ($urandom_range(0, 3) != 0);
            bus.has_int        = ($urandom_range(0, 7) == 0);
            bus.ws_ex          = ($urandom_range(0, 3) == 0);
            bus.ws_ertn        = ($urandom_range(0, 4) == 0);
            bus.ws_ecode       = 6'($urandom);
            bus.ws_esubcode    = 9'($urandom);
            bus.ws_pc          = $urandom;
            bus.ws_vaddr       = $urandom;
            bus.csr_eentry     = eentry;
            bus.csr_era        = $urandom;
            bus.redirect_ready = ($urandom_range(0, 2) != 0);
            #1;
            idle = (age < 0);
            ev   = idle && bus.ws_valid && (bus.has_int || bus.ws_ex || bus.ws_ertn);
            total++; if ({bus.ws_commit, bus.flush_all, bus.ws_allowin} !== {idle && bus.ws_valid && !ev, !idle || ev, idle && !ev}) begin
                bad++; $display("FAIL rnd_comb_%0d: got commit/flush/allowin=%b want %b", i,
                                {bus.ws_commit, bus.flush_all, bus.ws_allowin}, {idle && bus.ws_valid && !ev, !idle || ev, idle && !ev}); end
            total++; if ({bus.csr_wb_ex, bus.csr_ertn_flush, bus.redirect_valid} !== {age == 1 && !kind_ertn, age == 1 && kind_ertn, age >= 2}) begin
                bad++; $display("FAIL rnd_pulses_%0d: got wb_ex/ertn/rv=%b want %b", i,
                                {bus.csr_wb_ex, bus.csr_ertn_flush, bus.redirect_valid}, {age == 1 && !kind_ertn, age == 1 && kind_ertn, age >= 2}); end
            total++; if ({bus.csr_ecode, bus.csr_esubcode, bus.csr_pc, bus.csr_vaddr, bus.redirect_pc} !== {m_ecode, m_esub, m_pc, m_vaddr, m_rpc}) begin
                bad++; $display("FAIL rnd_fields_%0d: got %h want %h", i,
                                {bus.csr_ecode, bus.csr_esubcode, bus.csr_pc, bus.csr_vaddr, bus.redirect_pc}, {m_ecode, m_esub, m_pc, m_vaddr, m_rpc}); end
            total++; if (bus.ev_cnt !== 16'(cnt) || bus2.ev_cnt !== 2'(cnt2)) begin
                bad++; $display("FAIL rnd_cnt_%0d: got %0d/%0d want %0d/%0d", i, bus.ev_cnt, bus2.ev_cnt, cnt, cnt2); end
            if (ev) begin
                age = 1;
                kind_ertn = !bus.has_int && !bus.ws_ex;
                if (bus.has_int) begin
                    m_ecode = ECODE_INT; m_esub = 9'h0; m_pc = bus.ws_pc; m_vaddr = bus.ws_vaddr;
                end else if (bus.ws_ex) begin
                    m_ecode = bus.ws_ecode; m_esub = bus.ws_esubcode; m_pc = bus.ws_pc; m_vaddr = bus.ws_vaddr;
                end
            end else if (age == 1) begin
                age = 2;
                m_rpc = kind_ertn ? bus.csr_era : eentry;
                if (!kind_ertn) begin
                    cnt  = (cnt < 65535) ? cnt + 1 : cnt;
                    cnt2 = (cnt2 < 3) ? cnt2 + 1 : cnt2;
                end
            end else if (age >= 2) begin
                age = bus.redirect_ready ? -1 : age + 1;
            end
        end
        @(negedge clk);
        clear_inputs();
    endtask

    initial begin
        test_reset();
        test_exception();
        test_ertn();
        test_int_priority();
        test_ready_stall();
        test_async_reset();
        test_saturation();
        test_random(600);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
